// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and default constants for the run/stop/step
//                clock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Controller states; the encoding is fixed so the state is
    // recognisable on a logic analyser.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam int c_DEBOUNCE_CYCLES = 16;
    localparam int c_STEP_LENGTH     = 10;
    localparam int c_COUNT_WIDTH     = 16;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_control_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : clock_control_debouncer
//  Description : Two-flop synchroniser, stability counter and one-cycle
//                press pulse for a raw front-panel button.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_control_debouncer
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_press
);

    localparam int                    c_CW   = width_for(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0]       c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_press;
    logic [c_CW-1:0] r_count;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing
    // samples; the press pulse is registered on the same edge as the rise.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_count <= '0;
            end else if (r_count == c_LAST) begin
                r_level <= r_sync2;
                r_press <= r_sync2;
                r_count <= '0;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_control.sv
`default_nettype none
// ============================================================================
//  Module      : clock_control
//  Description : Run/stop/single-step controller driving the clock
//                generator enable, with debounced front-panel buttons and
//                halt handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_control
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int STEP_LENGTH     = c_STEP_LENGTH,
    parameter int COUNT_WIDTH     = c_COUNT_WIDTH
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_run,
    input  logic                   i_step,
    input  logic                   i_halt,
    input  logic                   i_clear,
    output logic                   o_enable,
    output logic                   o_running,
    output logic                   o_halted,
    output logic [COUNT_WIDTH-1:0] o_step_count
);

    localparam int              c_TW        = width_for(STEP_LENGTH);
    localparam logic [c_TW-1:0] c_STEP_LOAD = c_TW'(STEP_LENGTH - 1);

    logic                   w_run_press;
    logic                   w_step_press;
    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_step_start;
    logic                   w_enable;
    logic                   w_running;
    logic                   w_halted;
    logic [c_TW-1:0]        r_timer;
    logic [COUNT_WIDTH-1:0] r_step_count;
    logic                   r_enable;
    logic                   r_running;
    logic                   r_halted;

    clock_control_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_debounce (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_raw   (i_run),
        .o_press (w_run_press)
    );

    clock_control_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_raw   (i_step),
        .o_press (w_step_press)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt outranks every press, run outranks step.
    always_comb begin
        w_next_state = r_state;
        w_step_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_halt) begin
                    w_next_state = HALTED;
                end else if (w_run_press) begin
                    w_next_state = RUN;
                end else if (w_step_press) begin
                    w_next_state = STEP;
                    w_step_start = 1'b1;
                end
            end
            RUN: begin
                if (i_halt) begin
                    w_next_state = HALTED;
                end else if (w_run_press) begin
                    w_next_state = IDLE;
                end
            end
            STEP: begin
                if (i_halt) begin
                    w_next_state = HALTED;
                end else if (r_timer == '0) begin
                    w_next_state = IDLE;
                end
            end
            HALTED: begin
                if (i_clear && !i_halt) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they can be registered
    // alongside the state and never glitch.
    always_comb begin
        w_enable  = (w_next_state == RUN) || (w_next_state == STEP);
        w_running = (w_next_state == RUN);
        w_halted  = (w_next_state == HALTED);
    end

    // Registered Moore outputs; reset drops them immediately.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_enable  <= 1'b0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_enable  <= w_enable;
            r_running <= w_running;
            r_halted  <= w_halted;
        end
    end

    // Step timer and accepted-step counter (counter wraps silently).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_timer      <= '0;
            r_step_count <= '0;
        end else if (w_step_start) begin
            r_timer      <= c_STEP_LOAD;
            r_step_count <= r_step_count + COUNT_WIDTH'(1);
        end else if ((r_state == STEP) && (r_timer != '0)) begin
            r_timer <= r_timer - c_TW'(1);
        end
    end

    assign o_enable     = r_enable;
    assign o_running    = r_running;
    assign o_halted     = r_halted;
    assign o_step_count = r_step_count;

endmodule
`default_nettype wire
